// File: rtl/store_narrow_align_if.sv
// Store request / memory beat bundle for store_narrow_align.
// master: request producer and memory model side. slave: the store aligner.
interface store_narrow_align_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic [1:0]        in_size;
  logic              in_signed;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_last;
  logic              busy;
  logic              err;
  logic              ovf;

  modport master (
    output in_valid, in_addr, in_data, in_size, in_signed, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_last,
           busy, err, ovf
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_size, in_signed, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_last,
           busy, err, ovf
  );
endinterface

// File: rtl/store_narrow_align.sv
// Store-path narrowing and lane alignment. Narrows a register value to
// byte/half/word, shifts it onto little-endian lanes of a 32-bit word memory
// and splits word-crossing stores into two beats.
// Optional macro NARROW_OVF_CHECK_EN: flags byte/half stores whose discarded
// upper bits are not the sign/zero extension of the narrowed value.
module store_narrow_align #(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  store_narrow_align_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       hi_data_q, hi_data_d;
  logic [3:0]        be_q, be_d;
  logic [3:0]        hi_be_q, hi_be_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              beat_done;
  logic              mem_valid_w;
  logic              ovf_flag;
  logic [1:0]        off;
  logic [63:0]       data64;
  logic [7:0]        be8;

  // Keep only the bytes the access size covers.
  function automatic logic [31:0] narrow_fn(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'b0, d[7:0]};
      2'b01:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Byte-enable pattern of an aligned access of the given size.
  function automatic logic [3:0] mask_fn(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

`ifdef NARROW_OVF_CHECK_EN
  // Discarded upper bits must replicate the narrowed MSB (signed) or be zero.
  function automatic logic ovf_fn(input logic [31:0] d, input logic [1:0] sz, input logic sgn);
    case (sz)
      2'b00:   return sgn ? (d[31:8]  != {24{d[7]}})  : (d[31:8]  != 24'b0);
      2'b01:   return sgn ? (d[31:16] != {16{d[15]}}) : (d[31:16] != 16'b0);
      default: return 1'b0;
    endcase
  endfunction

  assign ovf_flag = ovf_fn(bus.in_data, bus.in_size, bus.in_signed);
`else
  logic unused_in_signed;
  assign unused_in_signed = bus.in_signed;
  assign ovf_flag         = 1'b0;
`endif

  assign mem_valid_w   = (state_q != IDLE);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_valid = mem_valid_w;
  assign bus.busy      = mem_valid_w;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_last  = last_q;
  assign bus.err       = err_q;
  assign bus.ovf       = ovf_q;

  assign accept    = bus.in_valid & (state_q == IDLE);
  assign beat_done = mem_valid_w & bus.mem_ready;
  assign off       = bus.in_addr[1:0];
  // The 64-bit window spans the addressed word and the one after it.
  assign data64    = {32'b0, narrow_fn(bus.in_data, bus.in_size)} << {off, 3'b000};
  assign be8       = {4'b0, mask_fn(bus.in_size)} << off;

  // Next-state and beat register updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hi_data_d = hi_data_q;
    be_d      = be_q;
    hi_be_d   = hi_be_q;
    last_d    = last_q;
    err_d     = 1'b0;
    ovf_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ovf_d = ovf_flag;
          if (bus.in_size == 2'b11) begin
            // Reserved size: swallow the request, report it, emit nothing.
            err_d = 1'b1;
          end else begin
            state_d   = BEAT0;
            addr_d    = {bus.in_addr[ADDR_W-1:2], 2'b00};
            wdata_d   = data64[31:0];
            be_d      = be8[3:0];
            last_d    = (be8[7:4] == 4'b0000);
            hi_data_d = data64[63:32];
            hi_be_d   = be8[7:4];
          end
        end
      end
      BEAT0: begin
        if (beat_done) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            state_d = BEAT1;
            addr_d  = addr_q + ADDR_W'(4);
            wdata_d = hi_data_q;
            be_d    = hi_be_q;
            last_d  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (beat_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and beat registers; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      hi_data_q <= '0;
      be_q      <= '0;
      hi_be_q   <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hi_data_q <= hi_data_d;
      be_q      <= be_d;
      hi_be_q   <= hi_be_d;
      last_q    <= last_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_store_narrow_align.sv
// Bench for store_narrow_align: directed cases plus randomized stores checked
// against a byte-address reference model.
module tb_store_narrow_align;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_narrow_align_if #(.ADDR_W(32)) bus ();

  store_narrow_align #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Every cycle with mem_valid high after an accept.
  logic [31:0] ob_addr[16];
  logic [31:0] ob_data[16];
  logic [3:0]  ob_be[16];
  logic        ob_last[16];
  logic        ob_rdy[16];
  int          ob_n;
  // Beats actually handed over (valid & ready).
  logic [31:0] hs_addr[4];
  logic [31:0] hs_data[4];
  logic [3:0]  hs_be[4];
  logic        hs_last[4];
  int          hs_n;
  logic        ob_err, ob_err2, ob_ovf, ob_timeout;
  logic        ob_rdy_t1, ob_rdy_after, ob_valid_after;

  // Reference model results.
  logic [31:0] ex_addr[2];
  logic [31:0] ex_data[2];
  logic [3:0]  ex_be[2];
  int          ex_n;
  logic        ex_err, ex_ovf;

  // Each stored byte k lands at byte address a+k; group bytes by word.
  task automatic model(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg);
    logic [31:0] first, ba;
    int nb, idx, lane;
    longint sv, lim;
    ex_n = 0;
    ex_err = (sz == 2'd3);
    ex_ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ex_data[i] = '0;
      ex_be[i]   = '0;
    end
    first = a & 32'hFFFF_FFFC;
    ex_addr[0] = first;
    ex_addr[1] = first + 32'd4;
    if (sz != 2'd3) begin
      nb = 1 << sz;
      ex_n = 1;
      for (int k = 0; k < nb; k++) begin
        ba   = a + k;
        idx  = ((ba & 32'hFFFF_FFFC) == first) ? 0 : 1;
        lane = int'(ba % 4);
        ex_data[idx][8*lane +: 8] = d[8*k +: 8];
        ex_be[idx][lane] = 1'b1;
        if (idx == 1) ex_n = 2;
      end
    end
`ifdef NARROW_OVF_CHECK_EN
    if (sz < 2'd2) begin
      lim = (sz == 2'd0) ? 64'd256 : 64'd65536;
      if (sg) begin
        sv = longint'($signed(d));
        ex_ovf = (sv < -(lim / 2)) || (sv >= lim / 2);
      end else begin
        ex_ovf = (longint'(d) >= lim);
      end
    end
`else
    lim = 0;
    sv  = longint'(sg);
`endif
  endtask

  // Drive one request and record what comes out; no judgement here.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sg, input int stall);
    int w;
    int stall_left;
    bit done;
    ob_n = 0; hs_n = 0; ob_timeout = 1'b0; done = 0; ob_err2 = 1'b0;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.in_ready) ob_timeout = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_addr   = a;
    bus.in_data   = d;
    bus.in_size   = sz;
    bus.in_signed = sg;
    bus.mem_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_data   = $urandom;
    bus.in_addr   = $urandom;
    ob_err    = bus.err;
    ob_ovf    = bus.ovf;
    ob_rdy_t1 = bus.in_ready;
    stall_left = stall;
    for (int c = 0; c < 16 && !done; c++) begin
      bus.mem_ready = (stall_left == 0);
      if (c == 1) ob_err2 = bus.err;
      if (bus.mem_valid) begin
        ob_addr[ob_n] = bus.mem_addr;
        ob_data[ob_n] = bus.mem_wdata;
        ob_be[ob_n]   = bus.mem_be;
        ob_last[ob_n] = bus.mem_last;
        ob_rdy[ob_n]  = bus.mem_ready;
        ob_n++;
        if (bus.mem_ready && hs_n < 4) begin
          hs_addr[hs_n] = bus.mem_addr;
          hs_data[hs_n] = bus.mem_wdata;
          hs_be[hs_n]   = bus.mem_be;
          hs_last[hs_n] = bus.mem_last;
          hs_n++;
          if (bus.mem_last) done = 1;
        end
      end else if (sz == 2'd3 && c >= 2) begin
        done = 1;
      end
      if (stall_left > 0) stall_left--;
      if (!done || sz != 2'd3) begin
        @(posedge clk); #1;
      end
    end
    if (!done) ob_timeout = 1'b1;
    ob_rdy_after   = bus.in_ready;
    ob_valid_after = bus.mem_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_size = 2'd2; bus.in_addr = 32'h1233; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.mem_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_last, bus.err, bus.ovf} !== 71'd0) begin
      errors++; $display("FAIL reset_outputs got addr %h data %h be %b last %b err %b ovf %b want all 0",
                         bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_last, bus.err, bus.ovf);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got %b want 0", bus.mem_valid); end
  endtask

  task automatic test_byte();
    run_req(32'h0000_1003, 32'hFFFF_FFA5, 2'd0, 1'b0, 0);
    checks++; if (hs_n !== 1 || ob_timeout) begin errors++; $display("FAIL byte_beats got %0d timeout %b want 1", hs_n, ob_timeout); end
    checks++; if ({hs_addr[0], hs_data[0], hs_be[0], hs_last[0]} !== {32'h0000_1000, 32'hA500_0000, 4'b1000, 1'b1}) begin
      errors++; $display("FAIL byte_beat0 got %h %h %b %b want 00001000 a5000000 1000 1", hs_addr[0], hs_data[0], hs_be[0], hs_last[0]);
    end
    checks++; if (ob_rdy_t1 !== 1'b0 || ob_rdy_after !== 1'b1) begin
      errors++; $display("FAIL byte_in_ready got t1 %b t2 %b want 0 1", ob_rdy_t1, ob_rdy_after);
    end
    checks++; if (ob_valid_after !== 1'b0) begin errors++; $display("FAIL byte_valid_drop got %b want 0", ob_valid_after); end
  endtask

  task automatic test_half_split();
    run_req(32'h0000_2003, 32'h0000_BEEF, 2'd1, 1'b0, 0);
    checks++; if (hs_n !== 2) begin errors++; $display("FAIL half_beats got %0d want 2", hs_n); end
    checks++; if ({hs_addr[0], hs_data[0], hs_be[0], hs_last[0]} !== {32'h0000_2000, 32'hEF00_0000, 4'b1000, 1'b0}) begin
      errors++; $display("FAIL half_beat0 got %h %h %b %b want 00002000 ef000000 1000 0", hs_addr[0], hs_data[0], hs_be[0], hs_last[0]);
    end
    checks++; if ({hs_addr[1], hs_data[1], hs_be[1], hs_last[1]} !== {32'h0000_2004, 32'h0000_00BE, 4'b0001, 1'b1}) begin
      errors++; $display("FAIL half_beat1 got %h %h %b %b want 00002004 000000be 0001 1", hs_addr[1], hs_data[1], hs_be[1], hs_last[1]);
    end
  endtask

  task automatic test_word_stall();
    run_req(32'h0000_3002, 32'h1122_3344, 2'd2, 1'b0, 3);
    checks++; if (ob_n !== 5 || hs_n !== 2) begin errors++; $display("FAIL stall_cycles got %0d/%0d want 5/2", ob_n, hs_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ob_addr[i], ob_data[i], ob_be[i], ob_last[i], ob_rdy[i]} !== {32'h0000_3000, 32'h3344_0000, 4'b1100, 1'b0, (i == 3)}) begin
        errors++; $display("FAIL stall_hold%0d got %h %h %b %b want 00003000 33440000 1100 0", i, ob_addr[i], ob_data[i], ob_be[i], ob_last[i]);
      end
    end
    checks++; if ({hs_addr[1], hs_data[1], hs_be[1], hs_last[1]} !== {32'h0000_3004, 32'h0000_1122, 4'b0011, 1'b1}) begin
      errors++; $display("FAIL stall_beat1 got %h %h %b %b want 00003004 00001122 0011 1", hs_addr[1], hs_data[1], hs_be[1], hs_last[1]);
    end
  endtask

  task automatic test_wrap();
    run_req(32'hFFFF_FFFD, 32'h1122_3344, 2'd2, 1'b0, 0);
    checks++; if ({hs_addr[0], hs_data[0], hs_be[0]} !== {32'hFFFF_FFFC, 32'h2233_4400, 4'b1110}) begin
      errors++; $display("FAIL wrap_beat0 got %h %h %b want fffffffc 22334400 1110", hs_addr[0], hs_data[0], hs_be[0]);
    end
    checks++; if (hs_n !== 2 || {hs_addr[1], hs_data[1], hs_be[1]} !== {32'h0, 32'h0000_0011, 4'b0001}) begin
      errors++; $display("FAIL wrap_beat1 got n %0d %h %h %b want 00000000 00000011 0001", hs_n, hs_addr[1], hs_data[1], hs_be[1]);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.in_valid = 1'b1; bus.in_addr = 32'h0000_3002; bus.in_data = 32'h1122_3344;
    bus.in_size = 2'd2; bus.in_signed = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b want 1", bus.mem_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({bus.mem_valid, bus.busy, bus.in_ready} !== 3'b001) begin
      errors++; $display("FAIL midrst_state got valid %b busy %b ready %b want 0 0 1", bus.mem_valid, bus.busy, bus.in_ready);
    end
    bus.mem_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.mem_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_beat got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reserved();
    run_req(32'h0000_0010, 32'hDEAD_BEEF, 2'd3, 1'b1, 0);
    checks++; if (ob_err !== 1'b1 || ob_err2 !== 1'b0) begin errors++; $display("FAIL rsv_err got %b%b want 10", ob_err, ob_err2); end
    checks++; if (ob_n !== 0 || ob_timeout) begin errors++; $display("FAIL rsv_no_beat got %0d beats timeout %b want 0", ob_n, ob_timeout); end
    checks++; if (ob_ovf !== 1'b0 || ob_rdy_after !== 1'b1) begin errors++; $display("FAIL rsv_misc got ovf %b ready %b want 0 1", ob_ovf, ob_rdy_after); end
  endtask

  task automatic test_ovf();
    logic [31:0] dv[4];
    logic [1:0]  sv[4];
    logic        sg[4];
    logic        want[4];
    dv[0] = 32'hFFFF_FF80; sv[0] = 2'd0; sg[0] = 1'b1;
    dv[1] = 32'h0000_0180; sv[1] = 2'd0; sg[1] = 1'b1;
    dv[2] = 32'h0000_FFFF; sv[2] = 2'd1; sg[2] = 1'b0;
    dv[3] = 32'h0001_0000; sv[3] = 2'd1; sg[3] = 1'b0;
`ifdef NARROW_OVF_CHECK_EN
    want[0] = 1'b0; want[1] = 1'b1; want[2] = 1'b0; want[3] = 1'b1;
`else
    for (int i = 0; i < 4; i++) want[i] = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      run_req(32'h0000_0040, dv[i], sv[i], sg[i], 0);
      checks++; if (ob_ovf !== want[i]) begin errors++; $display("FAIL ovf%0d got %b want %b", i, ob_ovf, want[i]); end
      checks++; if (hs_n !== 1) begin errors++; $display("FAIL ovf_store%0d got %0d beats want 1", i, hs_n); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic        sg;
    for (int n = 0; n < 80; n++) begin
      a  = $urandom;
      if (n % 5 == 0) a[31:2] = '1;
      d  = $urandom;
      if (n % 3 == 0) d[31:8] = {24{d[7]}};
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      model(a, d, sz, sg);
      run_req(a, d, sz, sg, int'($urandom_range(0, 2)));
      checks++; if (hs_n !== ex_n || ob_timeout) begin
        errors++; $display("FAIL rnd_beats req %0d addr %h size %0d got %0d timeout %b want %0d", n, a, sz, hs_n, ob_timeout, ex_n);
      end
      for (int i = 0; i < 2; i++) begin
        if (i < ex_n && i < hs_n) begin
          checks++;
          if ({hs_addr[i], hs_data[i], hs_be[i], hs_last[i]} !== {ex_addr[i], ex_data[i], ex_be[i], (i == ex_n - 1)}) begin
            errors++; $display("FAIL rnd_beat%0d req %0d got %h %h %b %b want %h %h %b %b", i, n,
                               hs_addr[i], hs_data[i], hs_be[i], hs_last[i], ex_addr[i], ex_data[i], ex_be[i], (i == ex_n - 1));
          end
        end
      end
      checks++; if (ob_err !== ex_err || ob_ovf !== ex_ovf) begin
        errors++; $display("FAIL rnd_flags req %0d got err %b ovf %b want %b %b", n, ob_err, ob_ovf, ex_err, ex_ovf);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.in_size = '0;
    bus.in_signed = 1'b0; bus.mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_byte();
    test_half_split();
    test_word_stall();
    test_wrap();
    test_reset_mid();
    test_reserved();
    test_ovf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
